// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in one cycle.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  div_if
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
        return ~x + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic                  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  is_signed_s;
    logic                  a_neg_s;
    logic                  b_neg_s;
    logic [DATA_WIDTH:0]   r_shift_s;
    logic [DATA_WIDTH:0]   trial_s;
    logic [DATA_WIDTH-1:0] q_next_s;
    logic [DATA_WIDTH-1:0] r_next_s;

    assign is_signed_s = ~div_if.op[0];
    assign a_neg_s     = is_signed_s & div_if.dividend[DATA_WIDTH-1];
    assign b_neg_s     = is_signed_s & div_if.divisor[DATA_WIDTH-1];

    // One restoring step: shift {R,Q} left, keep the subtraction only if it did not borrow.
    always_comb begin
        r_shift_s = {r_q, q_q[DATA_WIDTH-1]};
        trial_s   = r_shift_s - {1'b0, d_q};
        q_next_s  = {q_q[DATA_WIDTH-2:0], ~trial_s[DATA_WIDTH]};
        if (trial_s[DATA_WIDTH]) begin
            r_next_s = r_shift_s[DATA_WIDTH-1:0];
        end else begin
            r_next_s = trial_s[DATA_WIDTH-1:0];
        end
    end

    // Next-state logic for the IDLE/CALC/DONE sequencer and datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        r_d      = r_q;
        d_d      = d_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (div_if.flush) begin
                    state_d = S_IDLE;
                end else if (div_if.start) begin
                    if (div_if.divisor == ZERO) begin
                        result_d = div_if.op[1] ? div_if.dividend : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (is_signed_s && (div_if.dividend == INT_MIN) &&
                                 (div_if.divisor == ALL_ONES)) begin
                        result_d = div_if.op[1] ? ZERO : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        q_d     = a_neg_s ? negate(div_if.dividend) : div_if.dividend;
                        r_d     = ZERO;
                        d_d     = b_neg_s ? negate(div_if.divisor) : div_if.divisor;
                        cnt_d   = CNT_LAST;
                        negq_d  = a_neg_s ^ b_neg_s;
                        negr_d  = a_neg_s;
                        rem_d   = div_if.op[1];
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (div_if.flush) begin
                    state_d = S_IDLE;
                end else begin
                    q_d   = q_next_s;
                    r_d   = r_next_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == {CNT_WIDTH{1'b0}}) begin
                        if (rem_q) begin
                            result_d = negr_q ? negate(r_next_s) : r_next_s;
                        end else begin
                            result_d = negq_q ? negate(q_next_s) : q_next_s;
                        end
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            q_q      <= ZERO;
            r_q      <= ZERO;
            d_q      <= ZERO;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            rem_q    <= 1'b0;
            result_q <= ZERO;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            r_q      <= r_d;
            d_q      <= d_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign div_if.busy   = (state_q == S_CALC);
    assign div_if.done   = (state_q == S_DONE);
    assign div_if.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: normal ops, special cases, flush, restart, async reset.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    div_unit_if #(.DATA_WIDTH(32)) dif ();

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at #1 after a posedge; start is sampled on the next posedge (edge 0).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string tag);
        int lat;
        int busy_n;
        dif.start    = 1'b1;
        dif.op       = o;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (dif.done !== 1'b1 && lat < 40) begin
            if (dif.busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy cycles"}, busy_n, exp_lat);
        chk({tag, " result"}, dif.result, exp);
    endtask

    task automatic idle_chk(input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        chk({tag, " done low"}, {31'd0, dif.done}, 32'd0);
        chk({tag, " busy low"}, {31'd0, dif.busy}, 32'd0);
        chk({tag, " result held"}, dif.result, exp);
    endtask

    initial begin
        int lat;
        int seen_done;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        dif.start = 1'b0;
        dif.flush = 1'b0;
        dif.op = 2'b00;
        dif.dividend = 32'd0;
        dif.divisor = 32'd0;
        #12;
        chk("reset busy", {31'd0, dif.busy}, 32'd0);
        chk("reset done", {31'd0, dif.done}, 32'd0);
        chk("reset result", dif.result, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'b01, 32'd100, 32'd7, 32'd14, 32, "DIVU 100/7");
        idle_chk(32'd14, "DIVU 100/7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32, "REMU 100/7");
        run_op(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, "DIV -7/2");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, "REM -7/2");
        run_op(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32, "DIV 7/-2");
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32, "REM 7/-2");
        run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32, "DIVU big/max");
        run_op(2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "DIV 5/0");
        run_op(2'b10, 32'd5, 32'd0, 32'd5, 0, "REM 5/0");
        run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "DIV ovf");
        idle_chk(32'h80000000, "DIV ovf");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, "REM ovf");
        run_op(2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "DIV 5/0 again");
        idle_chk(32'hFFFFFFFF, "pre-flush");

        // Flush on the tenth CALC cycle: abort, no done, result untouched.
        dif.start = 1'b1; dif.op = 2'b01; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("flush pre busy", {31'd0, dif.busy}, 32'd1);
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush = 1'b0;
        chk("flush busy", {31'd0, dif.busy}, 32'd0);
        seen_done = 0;
        repeat (40) begin
            if (dif.done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        chk("flush no done", seen_done, 32'd0);
        chk("flush result", dif.result, 32'hFFFFFFFF);

        // Flush together with start cancels the accept.
        dif.start = 1'b1; dif.flush = 1'b1; dif.op = 2'b01;
        @(posedge clk); #1;
        dif.start = 1'b0; dif.flush = 1'b0;
        chk("start+flush busy", {31'd0, dif.busy}, 32'd0);
        chk("start+flush done", {31'd0, dif.done}, 32'd0);

        // Start and operand changes during CALC are ignored.
        dif.start = 1'b1; dif.op = 2'b01; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        dif.start = 1'b1; dif.op = 2'b11; dif.dividend = 32'd50; dif.divisor = 32'd3;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = 5;
        while (dif.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("restart ignored latency", lat, 32'd32);
        chk("restart ignored result", dif.result, 32'd14);

        // Back-to-back: new start issued in the DONE cycle.
        run_op(2'b11, 32'd1000, 32'd7, 32'd6, 32, "b2b first REMU");
        run_op(2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32, "b2b DIV -100/7");
        idle_chk(32'hFFFFFFF2, "b2b");

        // Asynchronous reset in the middle of CALC.
        dif.start = 1'b1; dif.op = 2'b01; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, dif.busy}, 32'd0);
        chk("async rst done", {31'd0, dif.done}, 32'd0);
        chk("async rst result", dif.result, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32, "DIVU max/1");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the multiplier inside the execute stage. Execute pulses start when a divide instruction is in E; the hazard unit holds F/D/E/M/W stalled while busy=1.
- The result is written into aluResultM when done=1.

Parameters:
- DATA_WIDTH, 32, operand/result width
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin division; sampled only when state is IDLE or DONE
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  DATA_WIDTH  rs1 value (forwarded), sampled with start
- divisor  input  DATA_WIDTH  rs2 value (forwarded), sampled with start
- flush  input  1  synchronous abort (branch flush of E); wins over start
- busy  output  1  high while iterating (CALC)
- done  output  1  one-cycle pulse; result valid
- result  output  DATA_WIDTH  quotient or remainder, held until next accepted start

Behaviour:
- States: IDLE, CALC, DONE. Reset (async) -> IDLE, busy=0, done=0, result=0, counter=0, internal regs 0.
- busy = (state==CALC). done = (state==DONE). Both are registered-state decodes with no combinational path from start.
- Signed ops (DIV, REM) take operand magnitudes. Record negQ = sign(dividend) XOR sign(divisor) and negR = sign(dividend).
- Accept (start=1 and flush=0 in IDLE or DONE):
  - divisor==0: result = all-ones (DIV/DIVU) or dividend (REM/REMU); next state DONE.
  - Signed overflow (op=00/10, dividend=0x80000000, divisor=0xFFFFFFFF): result = 0x80000000 (DIV) or 0 (REM); next state DONE.
  - Otherwise: load Q = |dividend|, R = 0, D = |divisor|, counter = DATA_WIDTH-1; next state CALC.
- CALC, each edge:
  - {R,Q} shifted left 1.
  - Trial = R_shifted - D, computed at DATA_WIDTH+1 bits.
  - If the trial is non-negative, R = trial and Q[0] = 1; else Q[0] = 0.
  - Counter decrements.
- Last iteration (counter==0):
  - Apply sign correction: quotient negated if negQ (signed op); remainder negated if negR (signed op).
  - Register the selected value into result; next state DONE.
- Latency: start accepted at edge 0. Normal ops: done high in the cycle after edge DATA_WIDTH (32). Special cases: done high in the cycle after edge 0 (1 cycle).
- DONE lasts exactly one cycle, then IDLE unless a new start is accepted in that cycle (back-to-back allowed). Result holds its value in IDLE.
- start while CALC: ignored (no restart, no error).
- flush: in CALC or DONE -> IDLE next edge. Result is not updated; done is not asserted for the aborted op. A flush in the same cycle as start cancels the accept.
- Operands are only sampled at accept, so changes to dividend/divisor during CALC have no effect.
- Remainder sign follows dividend; quotient truncates toward zero (RISC-V semantics).
- Async rst mid-CALC: immediately IDLE, outputs to reset values.

Test Plan:
- DIVU 100/7: start at edge 0 -> busy high for 32 cycles; done pulse in cycle after edge 32, result=14. REMU same operands -> result=2.
- DIV -7/2 -> result=0xFFFFFFFD (-3). REM -7/2 -> result=0xFFFFFFFF (-1). DIV 7/-2 -> 0xFFFFFFFD. REM 7/-2 -> 1.
- Divide by zero: DIV 5/0 -> done 1 cycle after start, result=0xFFFFFFFF, busy never high. REM 5/0 -> result=5.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> result=0x80000000 in 1 cycle. REM same operands -> 0.
- flush at cycle 10 of CALC on DIVU 100/7:
  - Required: IDLE next edge, no done pulse, result retains its prior value.
  - start asserted during CALC (no flush) is ignored.
  - Back-to-back start in the DONE cycle launches the next op with correct result.
- rst asserted asynchronously mid-CALC -> busy=0, done=0, result=0 without waiting for a clock edge. A following DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
